// File: rtl/bfp16_norm_round_pkg.sv
// Shared types and constants for the BFP16 post-add normaliser.
package bfp16_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [9:0]  EXP_MAX  = 10'd255;

  // Packed BFP16 word: {sign, exp[7:0], frac[6:0]}.
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bfp16_t;

  // Raw adder mantissa: [10] carry, [9] hidden, [8:2] fraction, [1] guard, [0] sticky.
  typedef logic [10:0] raw_mant_t;

  // Stage-1 register contents. exp is a two's-complement 10-bit value.
  // For special (exp==FF) words, sig[6:0] carries the passthrough fraction.
  typedef struct packed {
    logic       valid;
    logic       sign;
    logic [9:0] exp;
    logic [7:0] sig;
    logic       g;
    logic       s;
    logic       special;
  } norm_stage_t;

endpackage

// File: rtl/bfp16_norm_round_lzc_10bit.sv
// Combinational leading-zero count of a 10-bit value, MSB first.
module lzc_10bit (
  input  logic [9:0] i_data,
  output logic [3:0] o_count,
  output logic       o_zero
);

  // Priority encode from the MSB; an all-zero input reports 10.
  always_comb begin
    casez (i_data)
      10'b1?????????: o_count = 4'd0;
      10'b01????????: o_count = 4'd1;
      10'b001???????: o_count = 4'd2;
      10'b0001??????: o_count = 4'd3;
      10'b00001?????: o_count = 4'd4;
      10'b000001????: o_count = 4'd5;
      10'b0000001???: o_count = 4'd6;
      10'b00000001??: o_count = 4'd7;
      10'b000000001?: o_count = 4'd8;
      10'b0000000001: o_count = 4'd9;
      default:        o_count = 4'd10;
    endcase
    o_zero = (i_data == 10'd0);
  end

endmodule

// File: rtl/bfp16_norm_round.sv
// Two-stage post-add normaliser: stage 1 normalises, stage 2 rounds (RNE) and packs.
module bfp16_norm_round
  import bfp16_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int FTZ   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_sign,
  input  logic [EXP_W-1:0]     i_exp,
  input  raw_mant_t            i_mant,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [EXP_W+MAN_W:0] o_data,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  norm_stage_t s1_q, s1_d;
  logic        s2_valid_q;
  bfp16_t      data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        s2_load_s;
  logic [3:0]  lz_s;
  logic        lz_zero_s;
  logic [9:0]  shifted_s;
  logic        rnd_inc_s;
  logic        rnd_carry_s;
  logic [7:0]  rnd_sig_s;
  logic [9:0]  exp_rnd_s;

  // Stage 2 accepts when empty or when its word leaves this cycle.
  assign s2_load_s = ~s2_valid_q | i_ready;
  assign o_ready   = ~s1_q.valid | s2_load_s;

  lzc_10bit u_lzc (
    .i_data  (i_mant[9:0]),
    .o_count (lz_s),
    .o_zero  (lz_zero_s)
  );

  assign shifted_s = i_mant[9:0] << lz_s;

  // Stage 1 next state: normalise the incoming mantissa onto the hidden bit.
  always_comb begin
    s1_d = s1_q;
    if (o_ready) begin
      s1_d.valid   = i_valid;
      s1_d.sign    = i_sign;
      s1_d.exp     = {2'b00, i_exp};
      s1_d.sig     = 8'h00;
      s1_d.g       = 1'b0;
      s1_d.s       = 1'b0;
      s1_d.special = 1'b0;
      if (i_exp == 8'hFF) begin
        s1_d.special = 1'b1;
        s1_d.sig     = {1'b0, i_mant[8:2]};
      end else if (~i_mant[10] & lz_zero_s) begin
        // Exact zero: always +0, no flags (sig[7]=0 marks it downstream).
        s1_d.sign = 1'b0;
        s1_d.exp  = 10'd0;
      end else if (i_mant[10]) begin
        s1_d.sig = i_mant[10:3];
        s1_d.g   = i_mant[2];
        s1_d.s   = i_mant[1] | i_mant[0];
        s1_d.exp = {2'b00, i_exp} + 10'd1;
      end else if (i_mant[9]) begin
        s1_d.sig = i_mant[9:2];
        s1_d.g   = i_mant[1];
        s1_d.s   = i_mant[0];
      end else begin
        s1_d.sig = shifted_s[9:2];
        s1_d.g   = shifted_s[1];
        s1_d.s   = shifted_s[0];
        s1_d.exp = {2'b00, i_exp} - {6'd0, lz_s};
      end
    end else begin
      s1_d = s1_q;
    end
  end

  assign rnd_inc_s                = s1_q.g & (s1_q.s | s1_q.sig[0]);
  assign {rnd_carry_s, rnd_sig_s} = {1'b0, s1_q.sig} + {8'h00, rnd_inc_s};
  assign exp_rnd_s                = s1_q.exp + {9'd0, rnd_carry_s};

  // Stage 2 next state: round, range-check and pack the stage-1 word.
  always_comb begin
    data_d = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    if (s1_q.special) begin
      data_d = {s1_q.sign, 8'hFF, s1_q.sig[6:0]};
    end else if (~(rnd_carry_s | rnd_sig_s[7])) begin
      data_d = 16'h0000;
    end else if ((FTZ != 0) && ($signed(exp_rnd_s) <= $signed(10'd0))) begin
      data_d = {s1_q.sign, 15'h0000};
      unf_d  = 1'b1;
    end else if ($signed(exp_rnd_s) >= $signed(EXP_MAX)) begin
      data_d = {s1_q.sign, 8'hFF, 7'h00};
      ovf_d  = 1'b1;
    end else begin
      // On a rounding carry-out rnd_sig_s is 8'h00, i.e. fraction 0 of 1.0.
      data_d = {s1_q.sign, exp_rnd_s[7:0], rnd_sig_s[6:0]};
    end
  end

  // Stage 1 register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Stage 2 register; outputs hold while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        data_q <= data_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
      end else begin
        data_q <= data_q;
        ovf_q  <= ovf_q;
        unf_q  <= unf_q;
      end
    end else begin
      s2_valid_q <= s2_valid_q;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_data      = data_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_bfp16_norm_round.sv
// Directed self-checking bench for bfp16_norm_round.
module tb_bfp16_norm_round;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [10:0] i_mant;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_overflow;
  logic        o_underflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [10:0] m;
    logic [15:0] d;
    logic        ov;
    logic        un;
  } vec_t;

  bfp16_norm_round dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Drive one word into an idle pipe and wait (bounded) for it to emerge.
  task automatic run_one(input logic s, input logic [7:0] e, input logic [10:0] m,
                         output int lat, output logic [15:0] d, output logic ov, output logic un);
    bit found;
    @(negedge i_clk);
    i_sign = s; i_exp = e; i_mant = m; i_valid = 1'b1; i_ready = 1'b1;
    lat = -1; d = 16'h0000; ov = 1'b0; un = 1'b0; found = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      if (o_valid && !found) begin
        found = 1'b1; lat = c; d = o_data; ov = o_overflow; un = o_underflow;
      end
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_sign = 1'b0; i_exp = 8'd0; i_mant = 11'd0;
    repeat (2) @(negedge i_clk);
    #1;
    n_vec++;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_vec++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 16'h0000 ||
        o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h ov=%b un=%b want 1 0 0000 0 0",
               o_ready, o_valid, o_data, o_overflow, o_underflow);
    end
  endtask

  task automatic test_normalise;
    vec_t v[5];
    int lat; logic [15:0] d; logic ov, un;
    v[0] = '{1'b0, 8'd127, 11'h200, 16'h3F80, 1'b0, 1'b0};
    v[1] = '{1'b0, 8'd127, 11'h600, 16'h4040, 1'b0, 1'b0};
    v[2] = '{1'b0, 8'd127, 11'h010, 16'h3D00, 1'b0, 1'b0};
    v[3] = '{1'b1, 8'd127, 11'h200, 16'hBF80, 1'b0, 1'b0};
    v[4] = '{1'b0, 8'd127, 11'h001, 16'h3B00, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_one(v[i].s, v[i].e, v[i].m, lat, d, ov, un);
      n_vec++;
      if (d !== v[i].d || ov !== v[i].ov || un !== v[i].un) begin
        n_err++;
        $display("FAIL normalise[%0d]: got %h ov=%b un=%b want %h ov=%b un=%b",
                 i, d, ov, un, v[i].d, v[i].ov, v[i].un);
      end
      if (i == 0) begin
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL latency: got %0d want 2", lat); end
      end
    end
  endtask

  task automatic test_rounding;
    vec_t v[4];
    int lat; logic [15:0] d; logic ov, un;
    v[0] = '{1'b0, 8'd127, 11'h3FF, 16'h4000, 1'b0, 1'b0};
    v[1] = '{1'b0, 8'd127, 11'h202, 16'h3F80, 1'b0, 1'b0};
    v[2] = '{1'b0, 8'd127, 11'h206, 16'h3F82, 1'b0, 1'b0};
    v[3] = '{1'b0, 8'd127, 11'h60C, 16'h4042, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_one(v[i].s, v[i].e, v[i].m, lat, d, ov, un);
      n_vec++;
      if (d !== v[i].d || ov !== v[i].ov || un !== v[i].un) begin
        n_err++;
        $display("FAIL rounding[%0d]: got %h ov=%b un=%b want %h ov=%b un=%b",
                 i, d, ov, un, v[i].d, v[i].ov, v[i].un);
      end
    end
  endtask

  task automatic test_range;
    vec_t v[6];
    int lat; logic [15:0] d; logic ov, un;
    v[0] = '{1'b1, 8'd5,   11'h010, 16'h8000, 1'b0, 1'b1};
    v[1] = '{1'b0, 8'd1,   11'h100, 16'h0000, 1'b0, 1'b1};
    v[2] = '{1'b1, 8'd2,   11'h100, 16'h8080, 1'b0, 1'b0};
    v[3] = '{1'b0, 8'd254, 11'h400, 16'h7F80, 1'b1, 1'b0};
    v[4] = '{1'b0, 8'd254, 11'h3FF, 16'h7F80, 1'b1, 1'b0};
    v[5] = '{1'b0, 8'd254, 11'h200, 16'h7F00, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_one(v[i].s, v[i].e, v[i].m, lat, d, ov, un);
      n_vec++;
      if (d !== v[i].d || ov !== v[i].ov || un !== v[i].un) begin
        n_err++;
        $display("FAIL range[%0d]: got %h ov=%b un=%b want %h ov=%b un=%b",
                 i, d, ov, un, v[i].d, v[i].ov, v[i].un);
      end
    end
  endtask

  task automatic test_special;
    vec_t v[2];
    int lat; logic [15:0] d; logic ov, un;
    v[0] = '{1'b1, 8'hFF, 11'h2A8, 16'hFFAA, 1'b0, 1'b0};
    v[1] = '{1'b0, 8'hFF, 11'h000, 16'h7F80, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      run_one(v[i].s, v[i].e, v[i].m, lat, d, ov, un);
      n_vec++;
      if (d !== v[i].d || ov !== v[i].ov || un !== v[i].un) begin
        n_err++;
        $display("FAIL special[%0d]: got %h ov=%b un=%b want %h ov=%b un=%b",
                 i, d, ov, un, v[i].d, v[i].ov, v[i].un);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t w[4];
    int idx, got, first_c, last_c;
    w[0] = '{1'b0, 8'd127, 11'h200, 16'h3F80, 1'b0, 1'b0};
    w[1] = '{1'b0, 8'd127, 11'h600, 16'h4040, 1'b0, 1'b0};
    w[2] = '{1'b0, 8'd127, 11'h010, 16'h3D00, 1'b0, 1'b0};
    w[3] = '{1'b0, 8'd127, 11'h3FF, 16'h4000, 1'b0, 1'b0};
    idx = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge i_clk);
      i_ready = (c >= 5);
      if (idx < 4) begin
        i_valid = 1'b1; i_sign = w[idx].s; i_exp = w[idx].e; i_mant = w[idx].m;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (c == 1) begin
        n_vec++;
        if (o_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_c1: got %b want 1", o_ready); end
      end
      if (c >= 2 && c <= 4) begin
        n_vec++;
        if (o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_stall c%0d: got %b want 0", c, o_ready); end
        n_vec++;
        if (o_valid !== 1'b1 || o_data !== w[0].d) begin
          n_err++;
          $display("FAIL b2b_hold c%0d: got vld=%b data=%h want 1 %h", c, o_valid, o_data, w[0].d);
        end
      end
      if (o_valid && i_ready) begin
        if (got < 4) begin
          n_vec++;
          if (o_data !== w[got].d) begin
            n_err++;
            $display("FAIL b2b_order[%0d]: got %h want %h", got, o_data, w[got].d);
          end
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (i_valid && o_ready) idx++;
    end
    i_valid = 1'b0;
    n_vec++;
    if (got !== 4) begin n_err++; $display("FAIL b2b_count: got %0d words want 4", got); end
    n_vec++;
    if (first_c !== 5 || last_c !== 8) begin
      n_err++;
      $display("FAIL b2b_throughput: got out cycles %0d..%0d want 5..8", first_c, last_c);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] d; logic ov, un;
    @(negedge i_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_sign = 1'b0; i_exp = 8'd127; i_mant = 11'h200;
    @(negedge i_clk);
    i_mant = 11'h600;
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    n_vec++;
    if (o_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_inflight: got vld=%b want 1", o_valid); end
    i_rst = 1'b1;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b want 0 1", o_valid, o_ready);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      #1;
      n_vec++;
      if (o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale c%0d: got vld=%b want 0", c, o_valid); end
    end
    run_one(1'b1, 8'd100, 11'h000, lat, d, ov, un);
    n_vec++;
    if (d !== 16'h0000 || ov !== 1'b0 || un !== 1'b0 || lat !== 2) begin
      n_err++;
      $display("FAIL rstmid_zero: got %h ov=%b un=%b lat=%0d want 0000 0 0 2", d, ov, un, lat);
    end
  endtask

  initial begin
    test_reset();
    test_normalise();
    test_rounding();
    test_range();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
